ext_issue_buffer: RTL and testbench

//   Decode-stage scheduler for the immediate Extender. Accepts fetched instructions over a valid/ready

---
 rtl/ext_issue_buffer_pkg.sv | 61 ++++++
 rtl/ext_issue_buffer_extender.sv | 22 ++
 rtl/ext_issue_buffer.sv | 84 ++++++++
 tb/tb_ext_issue_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ext_issue_buffer_pkg.sv
// ext_issue_buffer_pkg: extension-op encodings, opcode constants and buffer entry type.
package ext_issue_buffer_pkg;
   localparam logic [7:0] EXTOP_ZERO = 8'd0;
   localparam logic [7:0] EXTOP_SIGN = 8'd1;
   localparam logic [7:0] EXTOP_LUI  = 8'd2;
   localparam logic [7:0] EXTOP_BR   = 8'd3;
   localparam logic [7:0] EXTOP_J    = 8'd4;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LWL   = 6'h22;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [7:0] extop;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      logic [31:0] imm;
      logic [7:0]  extop;
      logic [31:0] pc;
      logic        illegal;
   } ent_t;

   function automatic dec_t decode_op(input logic [5:0] op);
      dec_t d;
      d = '{extop: EXTOP_ZERO, illegal: 1'b0};
      case (op)
         OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI:             d.extop = EXTOP_ZERO;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW:                            d.extop = EXTOP_SIGN;
         OP_LUI:                                         d.extop = EXTOP_LUI;
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:    d.extop = EXTOP_BR;
         OP_J, OP_JAL:                                   d.extop = EXTOP_J;
         default:                                        d.illegal = 1'b1;
      endcase
      return d;
   endfunction
endpackage

// File: rtl/ext_issue_buffer_extender.sv
// ext_issue_buffer_extender: immediate extender for zero/sign/lui/branch/jump forms.
module ext_issue_buffer_extender
   import ext_issue_buffer_pkg::*;
(
   input  logic [15:0] num,
   input  logic [25:0] jal,
   input  logic [31:0] PC,
   input  logic [7:0]  Extop,
   output logic [31:0] result
);
   always_comb begin
      result = '0;
      case (Extop)
         EXTOP_ZERO: result = {16'd0, num};
         EXTOP_SIGN: result = {{16{num[15]}}, num};
         EXTOP_LUI:  result = {num, 16'd0};
         EXTOP_BR:   result = {{14{num[15]}}, num, 2'b00};
         EXTOP_J:    result = {PC[31:28], jal, 2'b00};
         default:    result = '0;
      endcase
   end
endmodule

// File: rtl/ext_issue_buffer.sv
// ext_issue_buffer: decodes ext op, extends the immediate and queues results in a 2-entry skid FIFO.
module ext_issue_buffer
   import ext_issue_buffer_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int W_EXTOP = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [31:0]        in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_imm,
   output logic [W_EXTOP-1:0] out_extop,
   output logic [31:0]        out_pc,
   output logic               out_illegal
);
   if (DEPTH != 2 || W_EXTOP != 8) begin : g_bad_param
      $error("ext_issue_buffer supports only DEPTH=2 and W_EXTOP=8");
   end

   dec_t        w_dec;
   logic [31:0] w_imm;
   ent_t        w_ent;
   logic        w_push;
   logic        w_pop;
   logic [1:0]  w_occ_nxt;
   logic [1:0]  r_occ;
   logic        r_rd;
   logic        r_wr;
   logic        r_in_ready;
   ent_t        r_mem [2];

   always_comb w_dec = decode_op(in_instr[31:26]);

   ext_issue_buffer_extender u_ext (
      .num    (in_instr[15:0]),
      .jal    (in_instr[25:0]),
      .PC     (in_pc),
      .Extop  (w_dec.extop),
      .result (w_imm)
   );

   assign w_ent     = '{imm: w_imm, extop: w_dec.extop, pc: in_pc, illegal: w_dec.illegal};
   assign w_push    = in_valid & r_in_ready;
   assign w_pop     = out_valid & out_ready;
   assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_occ      <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_in_ready <= 1'b1;
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
      end else if (flush) begin
         r_occ      <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_ent;
            r_wr        <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         r_occ      <= w_occ_nxt;
         r_in_ready <= w_occ_nxt < 2'd2;
      end
   end

   // Head is read straight from storage, so out_* never see in_* combinationally.
   assign in_ready    = r_in_ready;
   assign out_valid   = r_occ != 2'd0;
   assign out_imm     = r_mem[r_rd].imm;
   assign out_extop   = r_mem[r_rd].extop;
   assign out_pc      = r_mem[r_rd].pc;
   assign out_illegal = r_mem[r_rd].illegal;
endmodule

// File: tb/tb_ext_issue_buffer.sv
// tb_ext_issue_buffer: randomized and directed checks of ext_issue_buffer against a queue model.
module tb_ext_issue_buffer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [7:0]  out_extop;
   logic [31:0] out_pc;
   logic        out_illegal;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] imm;
      logic [7:0]  op;
      logic [31:0] pc;
      logic        ill;
   } m_t;

   m_t q[$];
   bit m_rdy = 1'b1;

   ext_issue_buffer dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_extop(out_extop),
      .out_pc(out_pc), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic m_t model_ext(input logic [31:0] ins, input logic [31:0] pc);
      m_t e;
      int op;
      int sx;
      op = int'(ins[31:26]);
      sx = int'(ins[15:0]);
      if (sx >= 32768) sx -= 65536;
      e.pc = pc;
      e.ill = 1'b0;
      e.op = 8'd0;
      e.imm = 32'(ins[15:0]);
      if (op inside {8, 9, 10, 11, 32, 33, 34, 35, 36, 37, 40, 41, 43}) begin
         e.op = 8'd1;
         e.imm = 32'(sx);
      end else if (op == 15) begin
         e.op = 8'd2;
         e.imm = 32'(ins[15:0]) * 65536;
      end else if (op inside {1, 4, 5, 6, 7}) begin
         e.op = 8'd3;
         e.imm = 32'(sx * 4);
      end else if (op inside {2, 3}) begin
         e.op = 8'd4;
         e.imm = (pc & 32'hF000_0000) + 32'(ins[25:0]) * 4;
      end else if (!(op inside {0, 12, 13, 14})) begin
         e.ill = 1'b1;
         e.imm = 32'(ins[15:0]);
      end
      if (e.ill) e.imm = 32'(ins[15:0]);
      return e;
   endfunction

   task automatic model_edge();
      bit do_pop;
      bit do_push;
      if (flush) begin
         q.delete();
         m_rdy = 1'b1;
      end else begin
         do_pop  = q.size() > 0 && out_ready;
         do_push = in_valid && m_rdy;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(model_ext(in_instr, in_pc));
         m_rdy = q.size() < 2;
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      if (q.size() != 0) begin
         chk("out_pc", out_pc, q[0].pc);
         chk("out_extop", 32'(out_extop), 32'(q[0].op));
         chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
         if (!q[0].ill) chk("out_imm", out_imm, q[0].imm);
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   logic [31:0] d_ins [6] = '{32'h3421_8000, 32'h2021_FFFC, 32'h3C01_1234,
                              32'h1000_FFFF, 32'h0C00_0010, 32'hFC00_0000};
   logic [31:0] d_pc  [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h3000, 32'h110};
   logic [31:0] d_imm [6] = '{32'h0000_8000, 32'hFFFF_FFFC, 32'h1234_0000,
                              32'hFFFF_FFFC, 32'h0000_0040, 32'h0};
   logic [7:0]  d_op  [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0};

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_extop", 32'(out_extop), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      reset_n = 1'b1;

      // reset asserted mid-stream with two entries buffered
      cyc(1'b1, 32'h2021_0001, 32'hA000, 1'b0, 1'b0);
      cyc(1'b1, 32'h2021_0002, 32'hA004, 1'b0, 1'b0);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd1);
      q.delete();
      m_rdy = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1'b1, 32'h3421_0055, 32'hB000, 1'b0, 1'b0);
      chk("post_rst_pc", out_pc, 32'hB000);
      drain();

      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, d_ins[i], d_pc[i], 1'b0, 1'b0);
         chk("dec_extop", 32'(out_extop), 32'(d_op[i]));
         chk("dec_illegal", 32'(out_illegal), 32'(i == 5));
         if (i != 5) chk("dec_imm", out_imm, d_imm[i]);
         cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end

      cyc(1'b1, 32'h2021_0010, 32'hC000, 1'b0, 1'b0);
      chk("bp_ready1", 32'(in_ready), 32'd1);
      cyc(1'b1, 32'h2021_0020, 32'hC004, 1'b0, 1'b0);
      chk("bp_ready2", 32'(in_ready), 32'd0);
      cyc(1'b1, 32'h2021_0030, 32'hC008, 1'b0, 1'b0);
      chk("bp_head", out_pc, 32'hC000);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      chk("bp_second", out_pc, 32'hC004);
      drain();

      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 32'h2400_0000 + 32'(i), 32'hD000 + 32'(i * 4), 1'b1, 1'b0);
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_pc", out_pc, 32'hD000 + 32'(i * 4));
      end
      drain();

      cyc(1'b1, 32'h2021_0001, 32'hE000, 1'b0, 1'b0);
      cyc(1'b1, 32'h2021_0002, 32'hE004, 1'b0, 1'b0);
      cyc(1'b1, 32'h2021_0003, 32'hE008, 1'b1, 1'b1);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      drain();

      for (int i = 0; i < 7; i++)
         cyc(1'(i % 2 == 0), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      drain();

      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
             1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
